// File: rtl/fmdll_div_ctrl.sv
// Frame divider controller for the FM-DLL: counts N-cycle periods grouped into
// M-period frames and steers the delay-line input select.
module fmdll_div_ctrl #(
  parameter int unsigned NW = 4,
  parameter int unsigned MW = 2
) (
  input  logic          clk_out,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [NW-1:0] cfg_N,
  input  logic [MW-1:0] cfg_M,
  output logic          cfg_ready,
  output logic [NW-1:0] N_counter,
  output logic [MW-1:0] M_counter,
  output logic          DIV_N,
  output logic          DIV_M,
  output logic [1:0]    Sel,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, INJECT, RUN, REALIGN} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_act, n_eff, n_d;
  logic [MW-1:0] m_act, m_eff, m_d;
  logic          load, frame, div_n_d, div_m_d;
  logic [1:0]    sel_d;

  always_comb begin
    load  = cfg_valid && cfg_ready;
    n_eff = n_act;
    m_eff = m_act;
    if (load) begin
      n_eff = (cfg_N == '0) ? NW'(1) : cfg_N;
      m_eff = (cfg_M == '0) ? MW'(1) : cfg_M;
    end

    n_d     = '0;
    m_d     = '0;
    frame   = 1'b0;
    state_d = IDLE;
    unique case (state_q)
      IDLE, REALIGN: begin
        if (en) begin
          n_d   = NW'(1);
          m_d   = MW'(1);
          frame = 1'b1;
        end
      end
      INJECT, RUN: begin
        // Wrap decision uses the active ratios; loads only occur at frame end.
        frame = 1'b1;
        if (N_counter == n_act) begin
          n_d = NW'(1);
          m_d = M_counter + MW'(1);
        end else begin
          n_d = N_counter + NW'(1);
          m_d = M_counter;
        end
      end
    endcase

    // Flags of the coming cycle compare against the ratios that frame will use.
    div_n_d = frame && (n_d == n_eff);
    div_m_d = div_n_d && (m_d == m_eff);
    if (frame)
      state_d = div_m_d ? REALIGN : ((m_d == MW'(1)) ? INJECT : RUN);

    unique case (state_d)
      INJECT:  sel_d = 2'b00;
      REALIGN: sel_d = 2'b01;
      default: sel_d = 2'b10;
    endcase
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_act     <= NW'(4);
      m_act     <= MW'(2);
      N_counter <= '0;
      M_counter <= '0;
      DIV_N     <= 1'b0;
      DIV_M     <= 1'b0;
      Sel       <= 2'b10;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      n_act     <= n_eff;
      m_act     <= m_eff;
      N_counter <= n_d;
      M_counter <= m_d;
      DIV_N     <= div_n_d;
      DIV_M     <= div_m_d;
      Sel       <= sel_d;
      busy      <= (state_d != IDLE);
      cfg_ready <= (state_d == IDLE) || (state_d == REALIGN);
    end
  end

endmodule

// File: tb/tb_fmdll_div_ctrl.sv
// Directed bench for fmdll_div_ctrl: vector table for frame sequencing and
// configuration handoff, hand sequences for reset behaviour.
module tb_fmdll_div_ctrl;

  logic       clk_out = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_N = '0;
  logic [1:0] cfg_M = '0;
  logic       cfg_ready;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N, DIV_M, busy;
  logic [1:0] Sel;

  int errors = 0;
  int checks = 0;

  fmdll_div_ctrl #(.NW(4), .MW(2)) dut (
    .clk_out(clk_out), .rst(rst), .en(en), .cfg_valid(cfg_valid),
    .cfg_N(cfg_N), .cfg_M(cfg_M), .cfg_ready(cfg_ready),
    .N_counter(N_counter), .M_counter(M_counter), .DIV_N(DIV_N),
    .DIV_M(DIV_M), .Sel(Sel), .busy(busy)
  );

  always #5 clk_out = ~clk_out;

  // Packed as {N, M, Sel, DIV_N, DIV_M, cfg_ready, busy}
  typedef struct packed {
    logic       en;
    logic       cv;
    logic [3:0] cn;
    logic [1:0] cm;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] pk(input logic [3:0] n, input logic [1:0] m,
                                     input logic [1:0] s, input logic dn,
                                     input logic dm, input logic r, input logic b);
    return {n, m, s, dn, dm, r, b};
  endfunction

  function automatic logic [11:0] outs();
    return {N_counter, M_counter, Sel, DIV_N, DIV_M, cfg_ready, busy};
  endfunction

  task automatic add(input logic e, input logic cv, input logic [3:0] cn,
                     input logic [1:0] cm, input logic [3:0] n, input logic [1:0] m,
                     input logic [1:0] s, input logic dn, input logic dm,
                     input logic r, input logic b);
    tbl.push_back('{en: e, cv: cv, cn: cn, cm: cm, exp: pk(n, m, s, dn, dm, r, b)});
  endtask

  task automatic chk(input string nm, input logic [11:0] exp);
    logic [11:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got N=%0d M=%0d Sel=%b DN=%b DM=%b rdy=%b busy=%b, want N=%0d M=%0d Sel=%b DN=%b DM=%b rdy=%b busy=%b",
               nm, act[11:8], act[7:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[11:8], exp[7:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step_chk(input string nm, input logic [11:0] exp);
    @(posedge clk_out);
    #1;
    chk(nm, exp);
    @(negedge clk_out);
  endtask

  initial begin
    // Default N=4, M=2 frame twice
    add(1,0,0,0, 1,1,2'b00,0,0,0,1);
    add(1,0,0,0, 2,1,2'b00,0,0,0,1);
    add(1,0,0,0, 3,1,2'b00,0,0,0,1);
    add(1,0,0,0, 4,1,2'b00,1,0,0,1);
    add(1,0,0,0, 1,2,2'b10,0,0,0,1);
    add(1,0,0,0, 2,2,2'b10,0,0,0,1);
    add(1,0,0,0, 3,2,2'b10,0,0,0,1);
    add(1,0,0,0, 4,2,2'b01,1,1,1,1);
    add(1,0,0,0, 1,1,2'b00,0,0,0,1);
    // Held request N=2, M=3 is ignored until the frame end
    add(1,1,2,3, 2,1,2'b00,0,0,0,1);
    add(1,1,2,3, 3,1,2'b00,0,0,0,1);
    add(1,1,2,3, 4,1,2'b00,1,0,0,1);
    add(1,1,2,3, 1,2,2'b10,0,0,0,1);
    add(1,1,2,3, 2,2,2'b10,0,0,0,1);
    add(1,1,2,3, 3,2,2'b10,0,0,0,1);
    add(1,1,2,3, 4,2,2'b01,1,1,1,1);
    add(1,1,2,3, 1,1,2'b00,0,0,0,1);
    add(1,0,0,0, 2,1,2'b00,1,0,0,1);
    add(1,0,0,0, 1,2,2'b10,0,0,0,1);
    add(1,0,0,0, 2,2,2'b10,1,0,0,1);
    add(1,0,0,0, 1,3,2'b10,0,0,0,1);
    add(1,0,0,0, 2,3,2'b01,1,1,1,1);
    // Back to 4/2, then drop en at (2,1): frame completes, then idle
    add(1,1,4,2, 1,1,2'b00,0,0,0,1);
    add(0,0,0,0, 2,1,2'b00,0,0,0,1);
    add(0,0,0,0, 3,1,2'b00,0,0,0,1);
    add(0,0,0,0, 4,1,2'b00,1,0,0,1);
    add(0,0,0,0, 1,2,2'b10,0,0,0,1);
    add(0,0,0,0, 2,2,2'b10,0,0,0,1);
    add(0,0,0,0, 3,2,2'b10,0,0,0,1);
    add(0,0,0,0, 4,2,2'b01,1,1,1,1);
    add(0,0,0,0, 0,0,2'b10,0,0,1,0);
    // N=3, M=1 configured in idle
    add(0,1,3,1, 0,0,2'b10,0,0,1,0);
    add(1,0,0,0, 1,1,2'b00,0,0,0,1);
    add(1,0,0,0, 2,1,2'b00,0,0,0,1);
    add(1,0,0,0, 3,1,2'b01,1,1,1,1);
    add(1,0,0,0, 1,1,2'b00,0,0,0,1);
    add(1,0,0,0, 2,1,2'b00,0,0,0,1);
    add(1,0,0,0, 3,1,2'b01,1,1,1,1);
    add(0,0,0,0, 0,0,2'b10,0,0,1,0);
    // Zero ratios load as 1: every cycle realigns
    add(0,1,0,0, 0,0,2'b10,0,0,1,0);
    add(1,0,0,0, 1,1,2'b01,1,1,1,1);
    add(1,0,0,0, 1,1,2'b01,1,1,1,1);
    // Load 4/2 on the wrap edge: next frame already uses the new ratios
    add(1,1,4,2, 1,1,2'b00,0,0,0,1);
    add(0,0,0,0, 2,1,2'b00,0,0,0,1);
    add(0,0,0,0, 3,1,2'b00,0,0,0,1);
    add(0,0,0,0, 4,1,2'b00,1,0,0,1);
    add(0,0,0,0, 1,2,2'b10,0,0,0,1);
    add(0,0,0,0, 2,2,2'b10,0,0,0,1);
    add(0,0,0,0, 3,2,2'b10,0,0,0,1);
    add(0,0,0,0, 4,2,2'b01,1,1,1,1);
    add(0,0,0,0, 0,0,2'b10,0,0,1,0);

    #1 rst = 1'b1;
    #2 chk("reset_state", pk(0,0,2'b10,0,0,1,0));
    @(negedge clk_out);
    rst = 1'b0;
    step_chk("idle_hold", pk(0,0,2'b10,0,0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].cv; cfg_N = tbl[i].cn; cfg_M = tbl[i].cm;
      step_chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Mid-frame async reset with N=5 active; restart must use reset ratios 4/2
    en = 1'b0; cfg_valid = 1'b1; cfg_N = 4'd5; cfg_M = 2'd2;
    step_chk("load5_idle", pk(0,0,2'b10,0,0,1,0));
    cfg_valid = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++)
      step_chk($sformatf("n5_%0d", k), pk(4'(k),1,2'b00,(k == 5),0,0,1));
    step_chk("n5_1_2", pk(1,2,2'b10,0,0,0,1));
    step_chk("n5_2_2", pk(2,2,2'b10,0,0,0,1));
    @(posedge clk_out);
    #1 chk("n5_3_2", pk(3,2,2'b10,0,0,0,1));
    #2 rst = 1'b1;
    #1 chk("async_rst", pk(0,0,2'b10,0,0,1,0));
    @(negedge clk_out);
    rst = 1'b0;
    step_chk("post_rst_1_1", pk(1,1,2'b00,0,0,0,1));
    step_chk("post_rst_2_1", pk(2,1,2'b00,0,0,0,1));
    step_chk("post_rst_3_1", pk(3,1,2'b00,0,0,0,1));
    step_chk("post_rst_4_1", pk(4,1,2'b00,1,0,0,1));
    step_chk("post_rst_1_2", pk(1,2,2'b10,0,0,0,1));
    en = 1'b0;
    step_chk("post_rst_2_2", pk(2,2,2'b10,0,0,0,1));
    step_chk("post_rst_3_2", pk(3,2,2'b10,0,0,0,1));
    step_chk("post_rst_4_2", pk(4,2,2'b01,1,1,1,1));
    step_chk("post_rst_idle", pk(0,0,2'b10,0,0,1,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmdll_div_ctrl.md
FMDLL_DIV_CTRL -- requirements
Module: fmdll_div_ctrl

Interface
REQ-001 The block SHALL have parameter NW, default 4, the width of the N divide ratio and N_counter.
REQ-002 The block SHALL have parameter MW, default 2, the width of the M group count and M_counter.
REQ-003 The block SHALL have port clk_out, input, 1, the single clock (DLL output clock); all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1, run enable.
REQ-006 The block SHALL have port cfg_valid, input, 1, new configuration offered.
REQ-007 The block SHALL have port cfg_N, input, NW, requested N.
REQ-008 The block SHALL have port cfg_M, input, MW, requested M.
REQ-009 The block SHALL have port cfg_ready, output, 1, configuration accepted this cycle when cfg_valid is also 1.
REQ-010 The block SHALL have port N_counter, output, NW, position within the current N period (1..N; 0 when idle).
REQ-011 The block SHALL have port M_counter, output, MW, index of the current N period within the frame (1..M; 0 when idle).
REQ-012 The block SHALL have port DIV_N, output, 1, high on the last cycle of every N period.
REQ-013 The block SHALL have port DIV_M, output, 1, high on the last cycle of every frame.
REQ-014 The block SHALL have port Sel, output, 2, delay-line input select: 00 inject clk_ext, 10 recirculate, 01 realign.
REQ-015 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The block SHALL hold active ratios N_act and M_act in registers; all counting SHALL use only N_act and M_act, never cfg_N or cfg_M directly.
REQ-017 The block SHALL load a cfg_N or cfg_M value of 0 as 1.
REQ-018 The state machine SHALL have exactly four states, IDLE, INJECT, RUN and REALIGN; Sel is 10 in IDLE, 00 in INJECT, 10 in RUN and 01 in REALIGN.
REQ-019 All outputs SHALL be registered and SHALL change only on a clk_out edge or on rst.
REQ-020 In IDLE with en=1, the next edge SHALL enter the frame with N_counter=1, M_counter=1 and state INJECT (or REALIGN if N_act=1 and M_act=1).
REQ-021 In a frame, N_counter SHALL increment each cycle and wrap from N_act to 1; on that wrap, M_counter SHALL increment and wrap from M_act to 1.
REQ-022 DIV_N SHALL be 1 exactly when N_counter==N_act.
REQ-023 DIV_M SHALL be 1 exactly when N_counter==N_act and M_counter==M_act.
REQ-024 The state SHALL be REALIGN exactly when DIV_M=1; otherwise it SHALL be INJECT when M_counter==1 and RUN otherwise.
REQ-025 With M_act=1, the frame SHALL be INJECT for N_act-1 cycles followed by one REALIGN cycle.
REQ-026 From REALIGN, the next edge SHALL start a new frame at (1,1) if en=1, or go to IDLE (counters 0, Sel=10, DIV_N=DIV_M=0) if en=0.
REQ-027 Deasserting en mid-frame SHALL NOT abort the frame; the frame SHALL complete first.
REQ-028 cfg_ready SHALL be 1 in IDLE and in REALIGN and 0 otherwise; cfg_valid with cfg_ready=1 SHALL load N_act and M_act on that edge.
REQ-029 A configuration loaded in REALIGN SHALL take effect from the immediately following frame; there SHALL be no partial-frame use of the new values.
REQ-030 cfg_valid while cfg_ready=0 SHALL be ignored; the requester SHALL hold cfg_valid until accepted.
REQ-031 When the counters wrap and a configuration loads on the same edge, the wrap SHALL use the old N_act/M_act and the new frame SHALL use the new values.

Reset
REQ-032 While rst=1, the block SHALL immediately force state IDLE, N_act=4, M_act=2, N_counter=0, M_counter=0, DIV_N=0, DIV_M=0, Sel=10 and busy=0; cfg_ready is 1, per the IDLE rule.
REQ-033 rst asserted mid-frame SHALL abandon the frame with no completion; after release, the block SHALL resume per REQ-020 only if en=1.

Verification
REQ-034 Reset then en=1, defaults N=4, M=2: (N_counter, M_counter, Sel) sequence (1,1,00)(2,1,00)(3,1,00)(4,1,00)(1,2,10)(2,2,10)(3,2,10)(4,2,01), repeating; DIV_N high at each 4, DIV_M high only at (4,2).
REQ-035 Configure N=3, M=1 in IDLE, then en=1: sequence (1,1,00)(2,1,00)(3,1,01) repeating; DIV_N=DIV_M=1 on every third cycle.
REQ-036 During a frame with N=4, M=2, hold cfg_valid with N=2, M=3: cfg_ready=0 until (4,2); load occurs there; next frame runs (1,1)(2,1)(1,2)(2,2)(1,3)(2,3) with Sel 00,00,10,10,10,01.
REQ-037 Drop en at (2,1) with N=4, M=2: the frame completes through (4,2,01), then the block is IDLE with counters 0, Sel=10 and busy=0.
REQ-038 cfg_N=0, cfg_M=0 loaded, then en=1: the block runs with N_act=M_act=1; every cycle is (1,1,01) with DIV_N=DIV_M=1.
REQ-039 Assert rst asynchronously at (3,2): the outputs immediately become IDLE values; with en=1 after release, the block restarts at (1,1,00) using N_act=4 and M_act=2.
